// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU memory bus arbiter.
package bus_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StXfer,
    StTurn
  } state_e;

  // Default master count and the owner-index width it implies.
  localparam int unsigned NUM_MASTERS_DFLT = 4;
  localparam int unsigned OWNER_W          = $clog2(NUM_MASTERS_DFLT);

  // Width of the watchdog counter; holds any TIMEOUT up to 255.
  localparam int unsigned TIMEOUT_W = 8;

  // Read/write encoding on mrw and bus_rw.
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester above the last owner, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         valid
);

  logic [W-1:0] sel;

  // Scan last+1 .. last+N (mod N); the first hit wins, so last itself is lowest priority.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sel   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      sel = W'((32'(last) + i) % N);
      if (!valid && req[sel]) begin
        valid    = 1'b1;
        idx      = sel;
        gnt[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and single-transfer sequencer for the shared CPU memory bus.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         mreq,
  input  logic [NUM_MASTERS-1:0]         mas,
  input  logic [NUM_MASTERS-1:0]         mrw,
  input  logic                           sack,
  output logic [NUM_MASTERS-1:0]         mgrnt,
  output logic                           bus_as,
  output logic                           bus_rw,
  output logic [$clog2(NUM_MASTERS)-1:0] bus_owner,
  output logic                           bus_busy,
  output logic                           bus_err
);

  localparam int unsigned         OW          = $clog2(NUM_MASTERS);
  localparam logic [TIMEOUT_W-1:0] TimeoutVal = TIMEOUT_W'(TIMEOUT);

  state_e                 state_q;
  logic [OW-1:0]          last_q;
  logic [TIMEOUT_W-1:0]   cnt_q;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [OW-1:0]          pick_idx;
  logic                   pick_valid;

  rr_pick #(
    .N(NUM_MASTERS),
    .W(OW)
  ) u_rr_pick (
    .req  (mreq),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  // Arbitration FSM, watchdog and registered grant/owner/error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      mgrnt     <= '0;
      bus_owner <= '0;
      cnt_q     <= '0;
      bus_err   <= 1'b0;
      last_q    <= OW'(NUM_MASTERS - 1);
    end else begin
      bus_err <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            mgrnt     <= pick_gnt;
            bus_owner <= pick_idx;
            cnt_q     <= '0;
            state_q   <= StGrant;
          end
        end
        StGrant: begin
          cnt_q <= cnt_q + TIMEOUT_W'(1);
          if (cnt_q == TimeoutVal) begin
            // A coincident sack counts as a clean release.
            mgrnt   <= '0;
            bus_err <= ~sack;
            state_q <= StTurn;
          end else if (mas[bus_owner]) begin
            state_q <= StXfer;
          end else if (!mreq[bus_owner]) begin
            // Owner gave up before strobing: release quietly.
            mgrnt   <= '0;
            state_q <= StTurn;
          end
        end
        StXfer: begin
          cnt_q <= cnt_q + TIMEOUT_W'(1);
          if (sack || (cnt_q == TimeoutVal)) begin
            mgrnt   <= '0;
            bus_err <= ~sack;
            state_q <= StTurn;
          end
        end
        StTurn: begin
          // One idle cycle with no grant; the owner becomes lowest priority next round.
          last_q  <= bus_owner;
          state_q <= StIdle;
        end
        default: begin
          mgrnt   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Forward the owner's strobe and direction while it holds the bus.
  always_comb begin
    bus_busy = (state_q == StGrant) || (state_q == StXfer);
    bus_as   = 1'b0;
    bus_rw   = WR;
    if (bus_busy) begin
      bus_as = mas[bus_owner];
      bus_rw = bus_as ? mrw[bus_owner] : WR;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (4 masters, TIMEOUT 15).
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] mreq;
  logic [3:0] mas;
  logic [3:0] mrw;
  logic       sack;
  logic [3:0] mgrnt;
  logic       bus_as;
  logic       bus_rw;
  logic [1:0] bus_owner;
  logic       bus_busy;
  logic       bus_err;

  int n_vec = 0;
  int n_err = 0;

  bus_arbiter #(
    .NUM_MASTERS(4),
    .TIMEOUT    (15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mreq     (mreq),
    .mas      (mas),
    .mrw      (mrw),
    .sack     (sack),
    .mgrnt    (mgrnt),
    .bus_as   (bus_as),
    .bus_rw   (bus_rw),
    .bus_owner(bus_owner),
    .bus_busy (bus_busy),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b1;
    mreq = '0;
    mas  = '0;
    mrw  = '0;
    sack = 1'b0;
    #1 rst = 1'b0;
    tick();
    check("rst_mgrnt", 32'(mgrnt), 0);
    check("rst_owner", 32'(bus_owner), 0);
    check("rst_busy", 32'(bus_busy), 0);
    check("rst_err", 32'(bus_err), 0);
    check("rst_as", 32'(bus_as), 0);
    @(negedge clk);
    rst = 1'b1;

    // Single request from master 1, read transfer.
    mreq = 4'b0010;
    tick();
    check("single_grant", 32'(mgrnt), 32'h2);
    check("single_owner", 32'(bus_owner), 1);
    check("single_busy", 32'(bus_busy), 1);
    check("single_as_pre", 32'(bus_as), 0);
    mas = 4'b0010;
    mrw = 4'b0010;
    #1;
    check("single_as", 32'(bus_as), 1);
    check("single_rw", 32'(bus_rw), 1);
    tick();
    sack = 1'b1;
    tick();
    check("single_rel_grant", 32'(mgrnt), 0);
    check("single_rel_busy", 32'(bus_busy), 0);
    check("single_rel_err", 32'(bus_err), 0);
    sack = 1'b0;
    mas  = '0;
    mrw  = '0;
    mreq = '0;
    tick();

    // Contention from a fresh reset: order 0,1,2,3,0 with a 2-cycle gap.
    reset_pulse();
    mreq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr_grant%0d", k), 32'(mgrnt), 32'(1 << (k % 4)));
      check($sformatf("rr_onehot%0d", k), 32'($countones(mgrnt)), 1);
      check($sformatf("rr_owner%0d", k), 32'(bus_owner), 32'(k % 4));
      mas = 4'(1 << (k % 4));
      tick();
      check($sformatf("rr_as%0d", k), 32'(bus_as), 1);
      tick();
      sack = 1'b1;
      tick();
      check($sformatf("rr_turn%0d", k), 32'(mgrnt), 0);
      sack = 1'b0;
      mas  = '0;
      if (k == 4) mreq = '0;
      tick();
      check($sformatf("rr_gap%0d", k), 32'(mgrnt), 0);
    end

    // Watchdog: master 2 strobes a write and is never acknowledged.
    mreq = 4'b0100;
    tick();
    check("wd_grant", 32'(mgrnt), 32'h4);
    mas = 4'b0100;
    #1;
    check("wd_as", 32'(bus_as), 1);
    check("wd_rw_write", 32'(bus_rw), 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check($sformatf("wd_quiet%0d", i), 32'(bus_err), 0);
    end
    check("wd_hold", 32'(mgrnt), 32'h4);
    mreq = 4'b1100;
    tick();
    check("wd_err", 32'(bus_err), 1);
    check("wd_rel", 32'(mgrnt), 0);
    mas = '0;
    tick();
    check("wd_err_pulse", 32'(bus_err), 0);
    tick();
    check("wd_next_m3", 32'(mgrnt), 32'h8);

    // Abandon: master 3 drops its request before strobing.
    mreq = 4'b0011;
    tick();
    check("ab3_rel", 32'(mgrnt), 0);
    check("ab3_err", 32'(bus_err), 0);
    tick();
    tick();
    check("ab_m0_grant", 32'(mgrnt), 32'h1);
    mreq = 4'b0010;
    tick();
    check("ab0_rel", 32'(mgrnt), 0);
    check("ab0_err", 32'(bus_err), 0);
    tick();
    tick();
    check("ab_m1_grant", 32'(mgrnt), 32'h2);

    // Sack lands in the same cycle as the timeout.
    mas = 4'b0010;
    for (int i = 0; i < 15; i++) tick();
    check("st_hold", 32'(mgrnt), 32'h2);
    sack = 1'b1;
    tick();
    check("st_err", 32'(bus_err), 0);
    check("st_rel", 32'(mgrnt), 0);
    check("st_busy", 32'(bus_busy), 0);
    sack = 1'b0;
    mas  = '0;
    mreq = '0;
    tick();

    // Asynchronous reset in the middle of a transfer.
    mreq = 4'b0100;
    tick();
    check("ar_grant", 32'(mgrnt), 32'h4);
    mas = 4'b0100;
    tick();
    check("ar_as", 32'(bus_as), 1);
    #2 rst = 1'b0;
    #1;
    check("ar_mgrnt", 32'(mgrnt), 0);
    check("ar_bus_as", 32'(bus_as), 0);
    check("ar_busy", 32'(bus_busy), 0);
    check("ar_err", 32'(bus_err), 0);
    mas = '0;
    @(negedge clk);
    rst  = 1'b1;
    mreq = 4'b1001;
    tick();
    check("ar_first_m0", 32'(mgrnt), 32'h1);
    mreq = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
